// File: rtl/writeback_arbiter_pkg.sv
// Shared widths and the writeback-result payload for the writeback arbiter.
package writeback_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_result_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Busy-register scoreboard: tracks destinations of in-flight multi-cycle ops
// and flags decode-stage sources that still await their write.
module wb_scoreboard
  import writeback_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  set_valid_i,
  input  logic [REG_ADDR_W-1:0] set_rd_i,
  input  logic                  clr_valid_i,
  input  logic [REG_ADDR_W-1:0] clr_rd_i,
  input  logic [REG_ADDR_W-1:0] rd_addr1_i,
  input  logic [REG_ADDR_W-1:0] rd_addr2_i,
  output logic                  hazard1_c_o,
  output logic                  hazard2_c_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Clear first so a same-cycle set of the same register wins; x0 never busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_valid_i) begin
      busy_d[clr_rd_i] = 1'b0;
    end
    if (set_valid_i && (set_rd_i != '0)) begin
      busy_d[set_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign hazard1_c_o = busy_q[rd_addr1_i];
  assign hazard2_c_o = busy_q[rd_addr2_i];

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: ALU > skid buffer > direct mem result,
// one-cycle registered write port. Define WB_BYPASS_EN to add operand forwarding.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  aluValid,
  input  logic [REG_ADDR_W-1:0] aluRd,
  input  logic [XLEN-1:0]       aluData,
  input  logic                  memValid,
  input  logic [REG_ADDR_W-1:0] memRd,
  input  logic [XLEN-1:0]       memData,
  output logic                  memReady,
  input  logic                  issueValid,
  input  logic [REG_ADDR_W-1:0] issueRd,
  input  logic [REG_ADDR_W-1:0] readAddress1,
  input  logic [REG_ADDR_W-1:0] readAddress2,
  output logic                  hazard1,
  output logic                  hazard2,
`ifdef WB_BYPASS_EN
  input  logic [XLEN-1:0]       rfData1,
  input  logic [XLEN-1:0]       rfData2,
  output logic [XLEN-1:0]       fwdData1,
  output logic [XLEN-1:0]       fwdData2,
`endif
  output logic                  writeEnable,
  output logic [REG_ADDR_W-1:0] writeAddress,
  output logic [XLEN-1:0]       writeData
);

  wb_result_t skid_q, skid_d;
  wb_result_t wr_q, wr_d;
  wb_result_t mem_in_c;
  wb_result_t commit_c;
  logic       mem_accept_c;
  logic       mem_commit_c;

  assign memReady     = ~skid_q.valid;
  assign mem_accept_c = memValid & ~skid_q.valid;
  assign mem_in_c     = '{valid: memValid, rd: memRd, data: memData};

  // Pick one result to commit; a mem result beaten by the ALU parks in the skid.
  always_comb begin
    skid_d       = skid_q;
    wr_d         = wr_q;
    wr_d.valid   = 1'b0;
    commit_c     = '0;
    mem_commit_c = 1'b0;
    if (aluValid) begin
      commit_c = '{valid: 1'b1, rd: aluRd, data: aluData};
      if (mem_accept_c) begin
        skid_d = mem_in_c;
      end
    end else if (skid_q.valid) begin
      commit_c     = skid_q;
      mem_commit_c = 1'b1;
      skid_d.valid = 1'b0;
    end else if (mem_accept_c) begin
      commit_c     = mem_in_c;
      mem_commit_c = 1'b1;
    end
    // x0 results are consumed without touching the held address/data.
    if (commit_c.valid && (commit_c.rd != '0)) begin
      wr_d = commit_c;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      skid_q <= '0;
      wr_q   <= '0;
    end else begin
      skid_q <= skid_d;
      wr_q   <= wr_d;
    end
  end

  assign writeEnable  = wr_q.valid;
  assign writeAddress = wr_q.rd;
  assign writeData    = wr_q.data;

  wb_scoreboard u_scoreboard (
    .clk         (clk),
    .rstN        (rstN),
    .set_valid_i (issueValid),
    .set_rd_i    (issueRd),
    .clr_valid_i (mem_commit_c),
    .clr_rd_i    (commit_c.rd),
    .rd_addr1_i  (readAddress1),
    .rd_addr2_i  (readAddress2),
    .hazard1_c_o (hazard1),
    .hazard2_c_o (hazard2)
  );

`ifdef WB_BYPASS_EN
  // Forward the value being written this cycle so decode sees it early.
  assign fwdData1 = (wr_q.valid && (wr_q.rd == readAddress1) && (readAddress1 != '0))
                    ? wr_q.data : rfData1;
  assign fwdData2 = (wr_q.valid && (wr_q.rd == readAddress2) && (readAddress2 != '0))
                    ? wr_q.data : rfData2;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: queue-based reference model checked
// every cycle, plus directed literal checks. Honors WB_BYPASS_EN.
module tb_writeback_arbiter;

  logic        clk;
  logic        rstN;
  logic        aluValid;
  logic [4:0]  aluRd;
  logic [31:0] aluData;
  logic        memValid;
  logic [4:0]  memRd;
  logic [31:0] memData;
  logic        memReady;
  logic        issueValid;
  logic [4:0]  issueRd;
  logic [4:0]  readAddress1;
  logic [4:0]  readAddress2;
  logic        hazard1;
  logic        hazard2;
  logic        writeEnable;
  logic [4:0]  writeAddress;
  logic [31:0] writeData;
`ifdef WB_BYPASS_EN
  logic [31:0] rfData1;
  logic [31:0] rfData2;
  logic [31:0] fwdData1;
  logic [31:0] fwdData2;
`endif

  writeback_arbiter dut (
    .clk          (clk),
    .rstN         (rstN),
    .aluValid     (aluValid),
    .aluRd        (aluRd),
    .aluData      (aluData),
    .memValid     (memValid),
    .memRd        (memRd),
    .memData      (memData),
    .memReady     (memReady),
    .issueValid   (issueValid),
    .issueRd      (issueRd),
    .readAddress1 (readAddress1),
    .readAddress2 (readAddress2),
    .hazard1      (hazard1),
    .hazard2      (hazard2),
`ifdef WB_BYPASS_EN
    .rfData1      (rfData1),
    .rfData2      (rfData2),
    .fwdData1     (fwdData1),
    .fwdData2     (fwdData2),
`endif
    .writeEnable  (writeEnable),
    .writeAddress (writeAddress),
    .writeData    (writeData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted mem results wait in order in a queue; one commit per cycle.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } res_t;

  res_t        m_pend[$];
  bit          m_we   = 1'b0;
  logic [4:0]  m_wa   = '0;
  logic [31:0] m_wd   = '0;
  bit   [31:0] m_busy = '0;

  task automatic model_reset();
    m_pend.delete();
    m_we   = 1'b0;
    m_wa   = '0;
    m_wd   = '0;
    m_busy = '0;
  endtask

  task automatic model_step();
    bit          have;
    bit          from_mem;
    bit          take_new;
    logic [4:0]  crd;
    logic [31:0] cdat;
    res_t        r;
    have     = 1'b0;
    from_mem = 1'b0;
    crd      = '0;
    cdat     = '0;
    take_new = memValid && (m_pend.size() == 0);
    if (aluValid) begin
      have = 1'b1; crd = aluRd; cdat = aluData;
    end else if (m_pend.size() != 0) begin
      r = m_pend.pop_front();
      have = 1'b1; from_mem = 1'b1; crd = r.rd; cdat = r.data;
    end else if (take_new) begin
      have = 1'b1; from_mem = 1'b1; crd = memRd; cdat = memData;
      take_new = 1'b0;
    end
    if (take_new) begin
      r.rd = memRd; r.data = memData;
      m_pend.push_back(r);
    end
    m_we = have && (crd != 5'd0);
    if (m_we) begin
      m_wa = crd;
      m_wd = cdat;
    end
    if (from_mem && (crd != 5'd0)) m_busy[crd] = 1'b0;
    if (issueValid && (issueRd != 5'd0)) m_busy[issueRd] = 1'b1;
  endtask

  always @(posedge clk or negedge rstN) begin
    if (!rstN) model_reset();
    else       model_step();
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("writeEnable",  32'(writeEnable),  32'(m_we));
    chk("writeAddress", 32'(writeAddress), 32'(m_wa));
    chk("writeData",    writeData,         m_wd);
    chk("memReady",     32'(memReady),     32'(m_pend.size() == 0));
    chk("hazard1",      32'(hazard1),      32'(m_busy[readAddress1]));
    chk("hazard2",      32'(hazard2),      32'(m_busy[readAddress2]));
`ifdef WB_BYPASS_EN
    chk("fwdData1", fwdData1,
        (m_we && m_wa == readAddress1 && readAddress1 != 5'd0) ? m_wd : rfData1);
    chk("fwdData2", fwdData2,
        (m_we && m_wa == readAddress2 && readAddress2 != 5'd0) ? m_wd : rfData2);
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    aluValid   = 1'b0;
    memValid   = 1'b0;
    issueValid = 1'b0;
  endtask

  initial begin
    rstN = 1'b0;
    idle();
    aluRd = '0; aluData = '0; memRd = '0; memData = '0; issueRd = '0;
    readAddress1 = '0; readAddress2 = '0;
`ifdef WB_BYPASS_EN
    rfData1 = '0; rfData2 = '0;
`endif
    @(negedge clk);
    chk("rst_we",    32'(writeEnable), 32'd0);
    chk("rst_ready", 32'(memReady),    32'd1);
    chk("rst_haz1",  32'(hazard1),     32'd0);
    cyc(); cyc();
    rstN = 1'b1;

    // Single ALU result, one-cycle pulse
    aluValid = 1'b1; aluRd = 5'd5; aluData = 32'hDEADBEEF;
    cyc(); idle();
    @(negedge clk);
    chk("alu_we",   32'(writeEnable),  32'd1);
    chk("alu_wa",   32'(writeAddress), 32'd5);
    chk("alu_wd",   writeData,         32'hDEADBEEF);
    cyc();
    @(negedge clk);
    chk("alu_we_drop", 32'(writeEnable), 32'd0);

    // ALU/mem collision goes through the skid buffer
    cyc();
    aluValid = 1'b1; aluRd = 5'd3; aluData = 32'h11;
    memValid = 1'b1; memRd = 5'd7; memData = 32'h22;
    @(negedge clk);
    chk("col_ready0", 32'(memReady), 32'd1);
    cyc(); idle();
    @(negedge clk);
    chk("col1_wa",    32'(writeAddress), 32'd3);
    chk("col1_wd",    writeData,         32'h11);
    chk("col1_ready", 32'(memReady),     32'd0);
    cyc();
    @(negedge clk);
    chk("col2_we",    32'(writeEnable),  32'd1);
    chk("col2_wa",    32'(writeAddress), 32'd7);
    chk("col2_wd",    writeData,         32'h22);
    chk("col2_ready", 32'(memReady),     32'd1);

    // Held mem request waits for the skid to drain, then commits in order
    cyc();
    aluValid = 1'b1; aluRd = 5'd1; aluData = 32'h101;
    memValid = 1'b1; memRd = 5'd2; memData = 32'h202;
    cyc();
    aluValid = 1'b0; memRd = 5'd10; memData = 32'h1010;
    cyc();
    @(negedge clk);
    chk("hold_wa2", 32'(writeAddress), 32'd2);
    cyc(); idle();
    @(negedge clk);
    chk("hold_wa10", 32'(writeAddress), 32'd10);
    chk("hold_wd10", writeData,         32'h1010);

    // Scoreboard set, clear, and same-cycle set-wins
    cyc();
    issueValid = 1'b1; issueRd = 5'd9; readAddress1 = 5'd9;
    cyc(); idle();
    @(negedge clk);
    chk("sb_set", 32'(hazard1), 32'd1);
    cyc();
    memValid = 1'b1; memRd = 5'd9; memData = 32'h99;
    cyc(); idle();
    @(negedge clk);
    chk("sb_clr_wa", 32'(writeAddress), 32'd9);
    cyc();
    @(negedge clk);
    chk("sb_clr", 32'(hazard1), 32'd0);
    cyc();
    issueValid = 1'b1; issueRd = 5'd9;
    memValid = 1'b1; memRd = 5'd9; memData = 32'h98;
    cyc(); idle();
    @(negedge clk);
    chk("sb_setwins", 32'(hazard1), 32'd1);
    chk("sb_setwins_wd", writeData, 32'h98);
    cyc();
    memValid = 1'b1; memRd = 5'd9; memData = 32'h97;
    cyc(); idle();

    // Zero register: no write, held address/data, never busy
    cyc();
    aluValid = 1'b1; aluRd = 5'd0; aluData = 32'hFFFFFFFF;
    cyc(); idle();
    @(negedge clk);
    chk("x0_we", 32'(writeEnable), 32'd0);
    chk("x0_wd", writeData,        32'h97);
    cyc();
    issueValid = 1'b1; issueRd = 5'd0; readAddress1 = 5'd0;
    cyc(); idle();
    @(negedge clk);
    chk("x0_haz", 32'(hazard1), 32'd0);
    cyc();
    aluValid = 1'b1; aluRd = 5'd6; aluData = 32'h66;
    memValid = 1'b1; memRd = 5'd0; memData = 32'hAA;
    cyc(); idle();
    cyc();
    @(negedge clk);
    chk("x0_skid_we", 32'(writeEnable), 32'd0);
    chk("x0_skid_wd", writeData,        32'h66);

    // Reset with the skid full and x4 busy
    cyc();
    issueValid = 1'b1; issueRd = 5'd4; readAddress2 = 5'd4;
    cyc();
    issueValid = 1'b0;
    aluValid = 1'b1; aluRd = 5'd1; aluData = 32'h1;
    memValid = 1'b1; memRd = 5'd2; memData = 32'h2;
    cyc(); idle();
    @(negedge clk);
    chk("pre_rst_ready", 32'(memReady), 32'd0);
    chk("pre_rst_haz2",  32'(hazard2),  32'd1);
    #2 rstN = 1'b0;
    @(negedge clk);
    chk("mid_rst_we",    32'(writeEnable),  32'd0);
    chk("mid_rst_wa",    32'(writeAddress), 32'd0);
    chk("mid_rst_wd",    writeData,         32'd0);
    chk("mid_rst_ready", 32'(memReady),     32'd1);
    chk("mid_rst_haz2",  32'(hazard2),      32'd0);
    cyc();
    rstN = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    chk("post_rst_we", 32'(writeEnable), 32'd0);

`ifdef WB_BYPASS_EN
    // Forwarding of an in-flight write
    cyc();
    aluValid = 1'b1; aluRd = 5'd12; aluData = 32'hCAFE;
    readAddress2 = 5'd12; rfData2 = 32'h0;
    cyc(); idle();
    @(negedge clk);
    chk("fwd_hit", fwdData2, 32'hCAFE);
    #1 readAddress2 = 5'd0; rfData2 = 32'h1234;
    #1 chk("fwd_x0", fwdData2, 32'h1234);
`endif

    // Mixed traffic with every-cycle model checking
    for (int i = 0; i < 300; i++) begin
      cyc();
      aluValid     = ($urandom_range(0, 2) == 0);
      aluRd        = 5'($urandom_range(0, 15));
      aluData      = $urandom;
      memValid     = ($urandom_range(0, 1) == 0);
      memRd        = 5'($urandom_range(0, 15));
      memData      = $urandom;
      issueValid   = ($urandom_range(0, 3) == 0);
      issueRd      = 5'($urandom_range(0, 15));
      readAddress1 = 5'($urandom_range(0, 15));
      readAddress2 = 5'($urandom_range(0, 15));
`ifdef WB_BYPASS_EN
      rfData1      = $urandom;
      rfData2      = $urandom;
`endif
    end
    cyc(); idle();
    cyc(); cyc();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Port list SHALL be, in order: name, direction, width, meaning.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rstN  in  1  asynchronous, active-low reset.
REQ-004 aluValid / aluRd / aluData  in  1 / 5 / 32  single-cycle ALU result; always accepted, no ready.
REQ-005 memValid / memRd / memData  in  1 / 5 / 32  multi-cycle load/mul result.
REQ-006 memReady  out  1  mem result accepted this cycle when memValid and memReady are both high.
REQ-007 issueValid / issueRd  in  1 / 5  multi-cycle op issued; its destination becomes busy.
REQ-008 readAddress1 / readAddress2  in  5 / 5  decode-stage source registers.
REQ-009 hazard1 / hazard2  out  1 / 1  source register has a pending multi-cycle write.
REQ-010 writeEnable / writeAddress / writeData  out  1 / 5 / 32  register-file write port, registered.

Function
REQ-011 Writeback latency SHALL be one cycle: an accepted result appears on the write port on the next rising edge.
REQ-012 Priority SHALL be ALU first, then the skid buffer, then a direct mem result.
REQ-013 A one-entry skid buffer SHALL capture an accepted mem result that loses arbitration to the ALU.
REQ-014 memReady SHALL equal "skid buffer empty".
REQ-015 When the buffer is full, the buffer SHALL drain before any new mem result is accepted, so mem results commit in acceptance order.
REQ-016 A result with rd = 0 SHALL be consumed with writeEnable low and writeAddress/writeData held.
REQ-017 writeEnable SHALL be high for exactly one cycle per committed nonzero-rd result and low otherwise.
REQ-018 Scoreboard: 32-bit busy vector; issueValid with issueRd != 0 sets busy[issueRd].
REQ-019 Scoreboard: a mem commit to rd clears busy[rd].
REQ-020 If a set and a clear target the same register in the same cycle, set SHALL win.
REQ-021 busy[0] SHALL be constant 0.
REQ-022 hazardN SHALL equal busy[readAddressN], purely combinational.
REQ-023 An ALU commit SHALL NOT alter the busy vector.

Reset
REQ-024 When rstN is low, asynchronously: writeEnable=0, writeAddress=0, writeData=0, skid buffer empty, busy=0.
REQ-025 Consequently, during reset memReady=1 and hazard1=hazard2=0.
REQ-026 A result held in the skid buffer when reset asserts SHALL be discarded.
REQ-027 Reset SHALL be released synchronously to clk by the system; the block performs no internal synchronisation.

Configuration
REQ-028 Macro WB_BYPASS_EN SHALL control forwarding.
REQ-029 With WB_BYPASS_EN defined, ports SHALL be added: rfData1 / rfData2 (in, 32 each) and fwdData1 / fwdData2 (out, 32 each).
REQ-030 With WB_BYPASS_EN defined, fwdDataN SHALL be writeData when writeEnable=1, writeAddress=readAddressN and readAddressN != 0; otherwise fwdDataN SHALL be rfDataN.
REQ-031 With WB_BYPASS_EN undefined, those ports and that logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-032 A shared package SHALL hold REG_ADDR_W=5, XLEN=32, NUM_REGS=32 and the writeback-result struct {valid, rd, data}.
REQ-033 The busy vector and hazard lookup SHALL live in one sub-module, wb_scoreboard; arbitration and the skid buffer stay in the top level.

Verification
REQ-034 Single ALU result: aluValid=1, aluRd=5, aluData=0xDEADBEEF -> next cycle writeEnable=1, writeAddress=5, writeData=0xDEADBEEF, for one cycle only.
REQ-035 Collision: ALU rd=3, data=0x11 and mem rd=7, data=0x22 in the same cycle -> cycle+1 writes x3=0x11 with memReady=0; cycle+2 writes x7=0x22 with memReady=1.
REQ-036 Scoreboard: issue rd=9 -> hazard1=1 while readAddress1=9; mem commit rd=9 -> hazard1=0 the cycle after the write; issue and commit rd=9 in the same cycle -> busy[9] stays 1.
REQ-037 Zero register: ALU rd=0, data=0xFFFFFFFF -> writeEnable stays 0; issue rd=0 -> hazard stays 0 with readAddress=0.
REQ-038 Reset mid-operation: skid buffer full and busy[4]=1, pulse rstN low -> all outputs 0, memReady=1, hazards 0, and no write occurs after release.
REQ-039 With WB_BYPASS_EN: write x12=0xCAFE in flight, readAddress2=12, rfData2=0x0 -> fwdData2=0xCAFE; with readAddress2=0 -> fwdData2=rfData2.
